flag_ctrl: RTL and testbench

FLAG_CTRL -- requirements
Module: flag_ctrl

---
 rtl/flag_ctrl.sv | 111 +++++++++++
 tb/tb_flag_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/flag_ctrl.sv
// Flag update controller: computes next {Z,N,C} from ALU/carry controls and
// conditional jumps, and saves/restores flags through a one-deep interrupt shadow.
module flag_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_stall,
  input  logic [2:0] i_flags_cur,
  input  logic [2:0] i_alu_flags,
  input  logic       i_upd_zn,
  input  logic       i_upd_c,
  input  logic       i_setc,
  input  logic       i_clrc,
  input  logic [1:0] i_jmp_cond,
  input  logic       i_int_save,
  input  logic       i_rti,
  output logic [2:0] o_flags_next,
  output logic       o_branch_taken,
  output logic       o_shadow_valid,
  output logic       o_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    SAVED = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] shadow_q, shadow_d;
  logic [2:0] flags_q, flags_d;
  logic       branch_q, branch_d;
  logic       err_q, err_d;

  logic [2:0] f;
  logic       taken;

  // Candidate flags; a taken jump clears the flag it tested, evaluated on the current flags.
  always_comb begin
    f = i_flags_cur;
    if (i_upd_zn) f[2:1] = i_alu_flags[2:1];
    if (i_upd_c)  f[0]   = i_alu_flags[0];
    if (i_setc)   f[0]   = 1'b1;
    if (i_clrc)   f[0]   = 1'b0;
    taken = 1'b0;
    case (i_jmp_cond)
      2'b01: begin
        taken = i_flags_cur[2];
        if (taken) f[2] = 1'b0;
      end
      2'b10: begin
        taken = i_flags_cur[1];
        if (taken) f[1] = 1'b0;
      end
      2'b11: begin
        taken = i_flags_cur[0];
        if (taken) f[0] = 1'b0;
      end
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    flags_d  = flags_q;
    branch_d = branch_q;
    err_d    = 1'b0;
    if (!i_stall) begin
      flags_d  = f;
      branch_d = taken;
      if (i_rti && (state_q == SAVED)) begin
        // A valid restore wins over everything else; a concurrent save is an error.
        flags_d  = shadow_q;
        branch_d = 1'b0;
        state_d  = IDLE;
        err_d    = i_int_save;
      end else begin
        if (i_rti) err_d = 1'b1;
        if (i_int_save) begin
          if (state_q == IDLE) begin
            shadow_d = f;
            state_d  = SAVED;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= 3'b000;
      flags_q  <= 3'b000;
      branch_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      flags_q  <= flags_d;
      branch_q <= branch_d;
      err_q    <= err_d;
    end
  end

  assign o_flags_next   = flags_q;
  assign o_branch_taken = branch_q;
  assign o_shadow_valid = (state_q == SAVED);
  assign o_err          = err_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed and random checks of flag_ctrl against a bit-level reference model.
module tb_flag_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_stall;
  logic [2:0] i_flags_cur;
  logic [2:0] i_alu_flags;
  logic       i_upd_zn;
  logic       i_upd_c;
  logic       i_setc;
  logic       i_clrc;
  logic [1:0] i_jmp_cond;
  logic       i_int_save;
  logic       i_rti;
  logic [2:0] o_flags_next;
  logic       o_branch_taken;
  logic       o_shadow_valid;
  logic       o_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [2:0] m_flags;
  logic       m_branch;
  logic       m_saved;
  logic       m_err;
  logic [2:0] m_shadow;

  flag_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .i_stall        (i_stall),
    .i_flags_cur    (i_flags_cur),
    .i_alu_flags    (i_alu_flags),
    .i_upd_zn       (i_upd_zn),
    .i_upd_c        (i_upd_c),
    .i_setc         (i_setc),
    .i_clrc         (i_clrc),
    .i_jmp_cond     (i_jmp_cond),
    .i_int_save     (i_int_save),
    .i_rti          (i_rti),
    .o_flags_next   (o_flags_next),
    .o_branch_taken (o_branch_taken),
    .o_shadow_valid (o_shadow_valid),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    rst = 1'b0; i_stall = 1'b0; i_flags_cur = 3'b000; i_alu_flags = 3'b000;
    i_upd_zn = 1'b0; i_upd_c = 1'b0; i_setc = 1'b0; i_clrc = 1'b0;
    i_jmp_cond = 2'b00; i_int_save = 1'b0; i_rti = 1'b0;
  endtask

  // Model one clock edge from the rules, flag by flag.
  task automatic model_edge();
    logic z, n, c, tk;
    z = i_flags_cur[2]; n = i_flags_cur[1]; c = i_flags_cur[0];
    if (i_upd_zn) begin z = i_alu_flags[2]; n = i_alu_flags[1]; end
    if (i_upd_c) c = i_alu_flags[0];
    if (i_setc)  c = 1'b1;
    if (i_clrc)  c = 1'b0;
    tk = 1'b0;
    if (i_jmp_cond == 2'd1 && i_flags_cur[2]) begin tk = 1'b1; z = 1'b0; end
    if (i_jmp_cond == 2'd2 && i_flags_cur[1]) begin tk = 1'b1; n = 1'b0; end
    if (i_jmp_cond == 2'd3 && i_flags_cur[0]) begin tk = 1'b1; c = 1'b0; end
    if (rst) begin
      m_flags = 3'b000; m_branch = 1'b0; m_saved = 1'b0; m_err = 1'b0; m_shadow = 3'b000;
    end else if (i_stall) begin
      m_err = 1'b0;
    end else if (i_rti && m_saved) begin
      m_flags = m_shadow; m_branch = 1'b0; m_saved = 1'b0; m_err = i_int_save;
    end else begin
      m_flags  = {z, n, c};
      m_branch = tk;
      m_err    = i_rti || (i_int_save && m_saved);
      if (i_int_save && !m_saved) begin
        m_shadow = {z, n, c};
        m_saved  = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".flags"},  o_flags_next,           m_flags);
    check({tag, ".branch"}, {2'b00, o_branch_taken}, {2'b00, m_branch});
    check({tag, ".valid"},  {2'b00, o_shadow_valid}, {2'b00, m_saved});
    check({tag, ".err"},    {2'b00, o_err},          {2'b00, m_err});
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_flags = 3'bxxx;
    #1;
    rst = 1'b1;
    step("reset");
    check("reset_const_flags", o_flags_next, 3'b000);

    i_flags_cur = 3'b000; i_alu_flags = 3'b110; i_upd_zn = 1'b1;
    step("upd_zn");
    check("upd_zn_const", o_flags_next, 3'b110);

    i_flags_cur = 3'b101; i_jmp_cond = 2'b01;
    step("jz_taken");
    check("jz_const", {o_branch_taken, o_flags_next}, 4'b1001);
    i_flags_cur = 3'b101; i_jmp_cond = 2'b10;
    step("jn_not_taken");
    check("jn_const", {o_branch_taken, o_flags_next}, 4'b0101);
    i_flags_cur = 3'b011; i_jmp_cond = 2'b11;
    step("jc_taken");

    i_flags_cur = 3'b001; i_setc = 1'b1; i_clrc = 1'b1;
    step("clrc_over_setc");
    check("clrc_const", o_flags_next, 3'b000);

    i_flags_cur = 3'b011; i_int_save = 1'b1;
    step("save");
    i_flags_cur = 3'b011; i_alu_flags = 3'b110; i_upd_zn = 1'b1;
    step("upd_in_saved");
    check("upd_saved_const", o_flags_next, 3'b111);
    i_flags_cur = 3'b111; i_rti = 1'b1; i_jmp_cond = 2'b01;
    step("rti_restore");
    check("rti_const", {o_shadow_valid, o_flags_next}, 4'b0011);

    i_flags_cur = 3'b100; i_int_save = 1'b1;
    step("save2");
    i_flags_cur = 3'b010; i_int_save = 1'b1;
    step("save_in_saved");
    i_flags_cur = 3'b010;
    step("err_clears");
    i_flags_cur = 3'b001; i_rti = 1'b1;
    step("rti_shadow_kept");
    i_flags_cur = 3'b110; i_rti = 1'b1;
    step("rti_in_idle");
    i_flags_cur = 3'b111; i_int_save = 1'b1;
    step("save3");
    i_flags_cur = 3'b000; i_int_save = 1'b1; i_rti = 1'b1;
    step("save_and_rti");

    i_flags_cur = 3'b010; i_jmp_cond = 2'b10;
    step("pre_stall");
    i_stall = 1'b1; i_setc = 1'b1; i_rti = 1'b1;
    step("stall_hold");
    i_flags_cur = 3'b101; i_int_save = 1'b1;
    step("save4");
    rst = 1'b1; i_stall = 1'b1; i_setc = 1'b1;
    step("rst_in_saved");
    check("rst_const", {o_shadow_valid, o_err, o_branch_taken, o_flags_next}, 6'b000000);

    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 40) == 0);
      i_stall     = ($urandom_range(0, 7) == 0);
      i_flags_cur = 3'($urandom_range(0, 7));
      i_alu_flags = 3'($urandom_range(0, 7));
      i_upd_zn    = 1'($urandom_range(0, 1));
      i_upd_c     = 1'($urandom_range(0, 1));
      i_setc      = ($urandom_range(0, 3) == 0);
      i_clrc      = ($urandom_range(0, 3) == 0);
      i_jmp_cond  = 2'($urandom_range(0, 3));
      i_int_save  = ($urandom_range(0, 4) == 0);
      i_rti       = ($urandom_range(0, 4) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
